sdf_ntt_top: RTL and testbench
==============================

# sdf_ntt_top

Streaming 8-point number-theoretic transform (NTT) over Z_q, q = 7681, built as a radix-2 decimation-in-frequency single-path delay-feedback (SDF) pipeline. It accepts one coefficient per clock and emits one transformed coefficient per clock, in bit-reversed order by default. It is the NTT datapath core of the polynomial-multiplier subsystem.

## Interface
- `data_width`, 64: width of the `sdf_in` and `sdf_out` buses.
- `modulo`, 7681: prime modulus q; internal arithmetic width is W = ceil(log2(q)) = 13.
- `addr_width`, 3: log2(N), where N = 8. This is also the number of SDF stages.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `start` input, 1 bit: level enable. While high, one sample is accepted per clock and the pipeline advances.
- `sdf_in` input, `data_width` bits: input coefficient. It must be less than q. Bits above W are ignored.
- `sdf_out` output, `data_width` bits: output coefficient, zero-extended from W bits.
- `done_tick` output, 1 bit: one-cycle pulse while the last coefficient of a frame is on `sdf_out`.

## Operation
- Frame: N consecutive accepted samples x[0..7], computing X[k] = Σ x[n]·ω^(nk) mod q.
- ω = 1213 (primitive 8th root mod 7681). Powers: ω² = 4298, ω³ = 5756, ω⁴ = 7680.
- Stage s (s = 1, 2, 3) has a delay FIFO of depth 8/2^s, i.e. 4, 2, 1 words, each W bits wide.
- Each stage has a counter mod 2·depth, incremented only on an advance cycle.
  - Fill phase (counter < depth): the stage input is pushed into the FIFO. The FIFO head, i.e. the stored difference from the previous phase, is passed to the stage output.
  - Butterfly phase: with a = FIFO head and b = stage input, output (a+b) mod q and push ((a−b) mod q)·t mod q into the FIFO.
- Twiddle t, indexed by p = counter − depth:
  - stage 1: 1, 1213, 4298, 5756 for p = 0..3.
  - stage 2: 1, 4298.
  - stage 3: 1.
- Modular add/sub: one conditional ±q correction.
- Multiply: full 2W-bit product, then exact reduction mod q (Barrett or `%` are both acceptable). The result must be in [0, q).
- Each stage output is registered (one register per stage).
- Output order without the macro is bit-reversed: X0, X4, X2, X6, X1, X5, X3, X7.
- Back-to-back frames with no gap are supported. Counters wrap mod 2·depth, so frame boundaries need no control.
- done_tick is driven by an output-frame counter mod 8 that starts once the first valid output appears. It pulses on count 7.

## Timing
- Edge 0 is the first rising edge at which `start` = 1 after reset release; x[0] is sampled there.
- X-sample j (output order) is valid on `sdf_out` from just after edge 9+j until the next advance, for j = 0..7. Latency is 9 cycles.
- done_tick is high only in the cycle after edge 16 (for the first frame), then every 8 advance cycles while streaming.
- `start` low: all counters, FIFOs and registers hold. `sdf_out` holds its value and done_tick is 0. `start` must stay high (or new data must be fed) for the pipeline to drain.
- Reset (asserted at any time): every FIFO, register and counter clears to 0; `sdf_out` = 0; done_tick = 0. Any in-flight frame is discarded.
- Outputs produced before the first valid output (pipeline fill after reset) are don't-care values, but done_tick must stay 0 during that time.

## Configuration
- `SDF_BITREV_REORDER_EN` defined: a 2×8-word ping-pong buffer is added after stage 3.
  - It is written at bit-reversed address and read in natural order, so the output is X0..X7.
  - Latency increases by 8: X[j] is valid after edge 17+j, and done_tick is after edge 24.
- Undefined: no buffer. Output is bit-reversed with the timing given above.

## Test plan
- Reset then impulse x = 1,0,0,0,0,0,0,0 → all 8 outputs = 1; done_tick after edge 16.
- x = all 1 → outputs 8,0,0,0,0,0,0,0.
- x[1] = 1, others 0 → 1, 7680, 4298, 3383, 1213, 6468, 5756, 1925 (bit-reversed order); natural order 1, 1213, 4298, 5756, 7680, 6468, 3383, 1925 with `SDF_BITREV_REORDER_EN`.
- Frame of all 7680 followed immediately by a second frame of impulse: first frame outputs 7673 then 0s; second frame gives all 1s; done_tick pulses exactly 8 cycles apart.
- `start` dropped for 3 cycles mid-frame → output sequence identical to the uninterrupted run, delayed by 3 cycles; no done_tick during the stall.
- `rst_n` asserted at edge 5 of a frame → `sdf_out` = 0 and done_tick = 0 immediately; a new frame after release produces correct results with no residue from the aborted frame.

Source files
------------

// File: rtl/sdf_ntt_top_if.sv
// rtl/sdf_ntt_top_if.sv - stream port bundle for the 8-point SDF NTT core
interface sdf_ntt_top_if #(
    parameter int data_width = 64
);
    logic                  start;
    logic [data_width-1:0] sdf_in;
    logic [data_width-1:0] sdf_out;
    logic                  done_tick;

    modport master (output start, output sdf_in, input sdf_out, input done_tick);
    modport slave  (input start, input sdf_in, output sdf_out, output done_tick);
endinterface

// File: rtl/sdf_ntt_top.sv
// rtl/sdf_ntt_top.sv - radix-2 DIF SDF 8-point NTT over Z_7681, bit-reversed output
// Optional SDF_BITREV_REORDER_EN adds a ping-pong buffer for natural-order output.
module sdf_ntt_top #(
    parameter int data_width = 64,
    parameter int modulo     = 7681,
    parameter int addr_width = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    sdf_ntt_top_if.slave  bus
);
    localparam int W = $clog2(modulo);
    localparam logic [W-1:0] Q = modulo[W-1:0];
`ifdef SDF_BITREV_REORDER_EN
    localparam logic [4:0] LAT_C = 5'd17;
`else
    localparam logic [4:0] LAT_C = 5'd9;
`endif

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, Q}) s = s - {1'b0, Q};
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} - {1'b0, b};
        if (a < b) s = s + {1'b0, Q};
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        p = p % {{W{1'b0}}, Q};
        return p[W-1:0];
    endfunction

    logic [addr_width-1:0] g_q, g_d;
    logic [4:0]            fill_q, fill_d;
    logic [3:0][W-1:0]     fifo1_q, fifo1_d;
    logic [1:0][W-1:0]     fifo2_q, fifo2_d;
    logic [W-1:0]          fifo3_q, fifo3_d;
    logic [W-1:0]          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic                  done_q, done_d;
    logic [W-1:0]          x_in, push1, push2, push3, tw1, tw2, out_w;
    logic [1:0]            c2;
    logic                  unused_hi;

    assign x_in      = bus.sdf_in[W-1:0];
    assign unused_hi = &{1'b0, bus.sdf_in[data_width-1:W]};

`ifdef SDF_BITREV_REORDER_EN
    logic [1:0][7:0][W-1:0] rbuf_q, rbuf_d;
    logic                   wbank_q, wbank_d, rbank;
    logic [W-1:0]           out_q, out_d;
    logic [2:0]             wj, rk;
    assign out_w = out_q;
`else
    assign out_w = s3_q;
`endif

    always_comb begin
        g_d     = g_q;
        fill_d  = fill_q;
        fifo1_d = fifo1_q;
        fifo2_d = fifo2_q;
        fifo3_d = fifo3_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        s3_d    = s3_q;
        done_d  = 1'b0;
        push1   = '0;
        push2   = '0;
        push3   = '0;
        // Stage 2 sees frame sample i at edge 5+i, so its phase lags the global count by 5.
        c2      = g_q[1:0] + 2'd3;
        case (g_q[1:0])
            2'd0:    tw1 = W'(1);
            2'd1:    tw1 = W'(1213);
            2'd2:    tw1 = W'(4298);
            default: tw1 = W'(5756);
        endcase
        tw2 = c2[0] ? W'(4298) : W'(1);
        if (bus.start) begin
            g_d = g_q + 3'd1;
            if (fill_q != LAT_C) fill_d = fill_q + 5'd1;
            done_d = (fill_q == LAT_C) && (g_q == '0);

            if (!g_q[2]) begin
                push1 = x_in;
                s1_d  = fifo1_q[3];
            end else begin
                push1 = mod_mul(mod_sub(fifo1_q[3], x_in), tw1);
                s1_d  = mod_add(fifo1_q[3], x_in);
            end
            fifo1_d = {fifo1_q[2:0], push1};

            if (!c2[1]) begin
                push2 = s1_q;
                s2_d  = fifo2_q[1];
            end else begin
                push2 = mod_mul(mod_sub(fifo2_q[1], s1_q), tw2);
                s2_d  = mod_add(fifo2_q[1], s1_q);
            end
            fifo2_d = {fifo2_q[0], push2};

            if (!g_q[0]) begin
                push3 = s2_q;
                s3_d  = fifo3_q;
            end else begin
                push3 = mod_sub(fifo3_q, s2_q);
                s3_d  = mod_add(fifo3_q, s2_q);
            end
            fifo3_d = push3;
        end
    end

`ifdef SDF_BITREV_REORDER_EN
    // s3_q holds output slot wj; slot 0 of a read frame still shares the bank being finished.
    always_comb begin
        rbuf_d  = rbuf_q;
        wbank_d = wbank_q;
        out_d   = out_q;
        wj      = g_q - 3'd2;
        rk      = g_q - 3'd1;
        rbank   = (rk == 3'd0) ? wbank_q : ~wbank_q;
        if (bus.start) begin
            rbuf_d[wbank_q][{wj[0], wj[1], wj[2]}] = s3_q;
            out_d = rbuf_q[rbank][rk];
            if (wj == 3'd7) wbank_d = ~wbank_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbuf_q  <= '0;
            wbank_q <= 1'b0;
            out_q   <= '0;
        end else begin
            rbuf_q  <= rbuf_d;
            wbank_q <= wbank_d;
            out_q   <= out_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q     <= '0;
            fill_q  <= '0;
            fifo1_q <= '0;
            fifo2_q <= '0;
            fifo3_q <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            g_q     <= g_d;
            fill_q  <= fill_d;
            fifo1_q <= fifo1_d;
            fifo2_q <= fifo2_d;
            fifo3_q <= fifo3_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            done_q  <= done_d;
        end
    end

    assign bus.sdf_out   = {{(data_width-W){1'b0}}, out_w};
    assign bus.done_tick = done_q;
endmodule

// File: tb/tb_sdf_ntt_top.sv
// tb/tb_sdf_ntt_top.sv - scoreboard bench for sdf_ntt_top with directed NTT vectors
`timescale 1ns/1ps
module tb_sdf_ntt_top;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdf_ntt_top_if #(.data_width(64)) bus ();
    sdf_ntt_top dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef SDF_BITREV_REORDER_EN
    localparam int LAT = 17;
    localparam bit BITREV = 1'b0;
`else
    localparam int LAT = 9;
    localparam bit BITREV = 1'b1;
`endif

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    int n_adv = 0;
    bit adv_last = 1'b0;
    logic [63:0] last_exp = '0;
    bit have_last = 1'b0;
    int m_e;
    bit m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_adv <= 0;
            adv_last <= 1'b0;
        end else begin
            adv_last <= bus.start;
            if (bus.start) n_adv <= n_adv + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            m_e = n_adv - 1;
            m_done = adv_last && (m_e >= LAT) && (((m_e - LAT) % 8) == 7);
            checks++;
            if (bus.done_tick !== m_done) begin
                failures++;
                $display("FAIL done_tick edge=%0d got=%0b exp=%0b", m_e, bus.done_tick, m_done);
            end
            if (adv_last && m_e >= LAT) begin
                if (exp_q.size() > 0) begin
                    last_exp = exp_q.pop_front();
                    have_last = 1'b1;
                    checks++;
                    if (bus.sdf_out !== last_exp) begin
                        failures++;
                        $display("FAIL sdf_out edge=%0d got=%0d exp=%0d", m_e, bus.sdf_out, last_exp);
                    end
                end else begin
                    have_last = 1'b0;
                end
            end else if (!adv_last && have_last) begin
                checks++;
                if (bus.sdf_out !== last_exp) begin
                    failures++;
                    $display("FAIL stall_hold edge=%0d got=%0d exp=%0d", m_e, bus.sdf_out, last_exp);
                end
            end
        end
    end

    function automatic logic [7:0][12:0] mk(input int a0, input int a1, input int a2, input int a3,
                                            input int a4, input int a5, input int a6, input int a7);
        logic [7:0][12:0] v;
        v[0] = 13'(a0); v[1] = 13'(a1); v[2] = 13'(a2); v[3] = 13'(a3);
        v[4] = 13'(a4); v[5] = 13'(a5); v[6] = 13'(a6); v[7] = 13'(a7);
        return v;
    endfunction

    function automatic int brev3(input int j);
        return ((j & 1) << 2) | (j & 2) | ((j >> 2) & 1);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic step(input logic s, input logic [12:0] v);
        bus.start = s;
        bus.sdf_in = {32'($urandom), 19'($urandom), v};
        @(posedge clk);
        #1;
    endtask

    // Expected values are given in natural order; the bench reorders for bit-reversed output.
    task automatic frame(input logic [7:0][12:0] x, input logic [7:0][12:0] xk,
                         input int stall_at, input int stall_len);
        for (int j = 0; j < 8; j++)
            exp_q.push_back(64'(xk[BITREV ? brev3(j) : j]));
        for (int i = 0; i < 8; i++) begin
            if (i == stall_at)
                for (int k = 0; k < stall_len; k++) step(1'b0, 13'h1fff);
            step(1'b1, x[i]);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(1'b1, 13'd0);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout got=%0d exp=0 pending", exp_q.size());
        end
        step(1'b0, 13'd0);
        step(1'b0, 13'd0);
    endtask

    logic [7:0][12:0] v_imp, v_one, v_x1, v_x2, v_m1;
    logic [7:0][12:0] k_one, k_eight, k_x1, k_x2, k_m1;

    initial begin
        v_imp   = mk(1, 0, 0, 0, 0, 0, 0, 0);
        v_one   = mk(1, 1, 1, 1, 1, 1, 1, 1);
        v_x1    = mk(0, 1, 0, 0, 0, 0, 0, 0);
        v_x2    = mk(0, 0, 1, 0, 0, 0, 0, 0);
        v_m1    = mk(7680, 7680, 7680, 7680, 7680, 7680, 7680, 7680);
        k_one   = mk(1, 1, 1, 1, 1, 1, 1, 1);
        k_eight = mk(8, 0, 0, 0, 0, 0, 0, 0);
        k_x1    = mk(1, 1213, 4298, 5756, 7680, 6468, 3383, 1925);
        k_x2    = mk(1, 4298, 7680, 3383, 1, 4298, 7680, 3383);
        k_m1    = mk(7673, 0, 0, 0, 0, 0, 0, 0);

        bus.start = 1'b0;
        bus.sdf_in = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_sdf_out", bus.sdf_out, 64'd0);
        chk("reset_done", 64'(bus.done_tick), 64'd0);
        rst_n = 1'b1;
        step(1'b0, 13'd0);

        frame(v_imp, k_one,   -1, 0);
        frame(v_one, k_eight, -1, 0);
        frame(v_x1,  k_x1,    -1, 0);
        frame(v_m1,  k_m1,    -1, 0);
        frame(v_imp, k_one,   -1, 0);
        frame(v_x2,  k_x2,     3, 3);
        drain();

        for (int i = 0; i < 5; i++) step(1'b1, 13'd7680);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_sdf_out", bus.sdf_out, 64'd0);
        chk("midreset_done", 64'(bus.done_tick), 64'd0);
        exp_q.delete();
        have_last = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        frame(v_x1, k_x1, -1, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
